// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with valid/ready byte interfaces.
// TX and RX are independent; only clk and reset are shared.
module uart_transceiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  input  logic       serial_in,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME = SYMBOL_EDGE_TIME / 2;
  localparam int CW = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] SYM_LAST =
    CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SMP_LAST =
    CW'(SAMPLE_TIME - 1);

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_BUSY = 1'b1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [0:0]    tx_state;
  logic [9:0]    tx_shift;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;

  // Frame is {stop, data, start}; bit 0 is always on the wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_bit   <= '0;
      tx_cnt   <= '0;
    end else if (tx_state == TX_IDLE) begin
      if (data_in_valid) begin
        tx_state <= TX_BUSY;
        tx_shift <= {1'b1, data_in, 1'b0};
        tx_bit   <= '0;
        tx_cnt   <= '0;
      end
    end else if (tx_cnt == SYM_LAST) begin
      tx_cnt   <= '0;
      tx_shift <= {1'b1, tx_shift[9:1]};
      if (tx_bit == 4'd9) begin
        tx_state <= TX_IDLE;
      end else begin
        tx_bit <= tx_bit + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign data_in_ready = (tx_state == TX_IDLE);
  assign serial_out =
    (tx_state == TX_BUSY) ? tx_shift[0] : 1'b1;

  logic [1:0]    rx_sync;
  logic          rx;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], serial_in};
    end
  end

  assign rx = rx_sync[1];

  // Completion is written after the ready clear so a new byte wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state       <= RX_IDLE;
      rx_cnt         <= '0;
      rx_bit         <= '0;
      rx_shift       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (data_out_ready) begin
        data_out_valid <= 1'b0;
      end
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == SMP_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == SYM_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == SYM_LAST) begin
            rx_cnt         <= '0;
            rx_state       <= RX_IDLE;
            data_out       <= rx_shift;
            data_out_valid <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Two cross-connected UARTs at 50 MHz / 115200 baud,
// checked against a frame-level reference model.
module tb_uart_transceiver;

  localparam int BIT = 50_000_000 / 115_200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a_din = '0, b_din = '0;
  logic a_ivld = 0, b_ivld = 0;
  logic a_irdy, b_irdy;
  logic [7:0] a_dout, b_dout;
  logic a_ovld, b_ovld;
  logic a_ordy = 0, b_ordy = 0;
  logic a_so, b_so;
  logic gl_en = 0, gl = 1;
  logic b_si;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign b_si = gl_en ? gl : a_so;

  uart_transceiver #(.CLOCK_FREQ(50_000_000)) ua (
    .clk(clk), .reset(rst),
    .data_in(a_din), .data_in_valid(a_ivld),
    .data_in_ready(a_irdy),
    .data_out(a_dout), .data_out_valid(a_ovld),
    .data_out_ready(a_ordy),
    .serial_in(b_so), .serial_out(a_so)
  );

  uart_transceiver #(.CLOCK_FREQ(50_000_000)) ub (
    .clk(clk), .reset(rst),
    .data_in(b_din), .data_in_valid(b_ivld),
    .data_in_ready(b_irdy),
    .data_out(b_dout), .data_out_valid(b_ovld),
    .data_out_ready(b_ordy),
    .serial_in(b_si), .serial_out(b_so)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_a_idle(output int n);
    n = 0;
    while (!a_irdy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("a_idle_bound", a_irdy, 1);
  endtask

  // Accept on the next edge; leaves us at the negedge after it.
  task automatic send_a(input logic [7:0] d);
    int n;
    wait_a_idle(n);
    a_din = d;
    a_ivld = 1;
    @(negedge clk);
    a_ivld = 0;
    a_din = 8'($urandom);
    chk("a_busy_after_accept", a_irdy, 0);
    chk("a_start_bit", a_so, 0);
  endtask

  task automatic consume_b();
    b_ordy = 1;
    @(negedge clk);
    b_ordy = 0;
    chk("b_valid_cleared", b_ovld, 0);
  endtask

  task automatic consume_a();
    a_ordy = 1;
    @(negedge clk);
    a_ordy = 0;
    chk("a_valid_cleared", a_ovld, 0);
  endtask

  function automatic logic frame_bit(input logic [7:0] d,
                                     input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return d[i-1];
  endfunction

  logic [7:0] q_ab[$];
  logic [7:0] q_ba[$];

  initial begin
    int n;
    int good;
    int lows;
    logic [7:0] exp;

    cycles(3);
    rst = 0;
    @(negedge clk);
    chk("rst_so", a_so, 1);
    chk("rst_irdy", a_irdy, 1);
    chk("rst_ovld", b_ovld, 0);
    chk("rst_dout", b_dout, 8'h00);

    send_a(8'h7A);
    wait_a_idle(n);
    chk("tx_len_ok", (n >= 4339 && n <= 4342), 1);
    chk("rx_7a_valid", b_ovld, 1);
    chk("rx_7a_data", b_dout, 8'h7A);
    consume_b();

    send_a(8'hA5);
    for (int i = 0; i < 10; i++) begin
      good = 0;
      for (int c = 0; c < BIT; c++) begin
        if (a_so === frame_bit(8'hA5, i)) good++;
        @(negedge clk);
      end
      chk($sformatf("a5_bit%0d", i), good, BIT);
    end
    chk("a5_idle_so", a_so, 1);
    chk("a5_idle_rdy", a_irdy, 1);
    chk("rx_a5_data", b_dout, 8'hA5);
    consume_b();

    send_a(8'h7A);
    cycles(1000);
    a_din = 8'h33;
    a_ivld = 1;
    @(negedge clk);
    a_ivld = 0;
    chk("busy_ignores_req", a_irdy, 0);
    wait_a_idle(n);
    chk("ignore_data", b_dout, 8'h7A);
    consume_b();
    cycles(4500);
    chk("ignore_no_2nd", b_ovld, 0);

    send_a(8'h01);
    wait_a_idle(n);
    chk("b2b_first", b_dout, 8'h01);
    send_a(8'hFF);
    consume_b();
    wait_a_idle(n);
    chk("b2b_valid", b_ovld, 1);
    chk("b2b_second", b_dout, 8'hFF);
    consume_b();

    send_a(8'h11);
    wait_a_idle(n);
    chk("ovw_first", b_dout, 8'h11);
    send_a(8'h22);
    lows = 0;
    n = 0;
    while (!a_irdy && n < 6000) begin
      if (!b_ovld) lows++;
      @(negedge clk);
      n++;
    end
    chk("ovw_valid_held", lows, 0);
    chk("ovw_data", b_dout, 8'h22);
    consume_b();

    for (int k = 0; k < 4; k++) begin
      a_din = 8'($urandom);
      b_din = 8'($urandom);
      q_ab.push_back(a_din);
      q_ba.push_back(b_din);
      a_ivld = 1;
      b_ivld = 1;
      @(negedge clk);
      a_ivld = 0;
      b_ivld = 0;
      n = 0;
      while (!(a_irdy && b_irdy) && n < 6000) begin
        @(negedge clk);
        n++;
      end
      chk("dup_bound", a_irdy && b_irdy, 1);
      chk("dup_valid", a_ovld && b_ovld, 1);
      exp = q_ab.pop_front();
      chk($sformatf("dup_ab%0d", k), b_dout, exp);
      exp = q_ba.pop_front();
      chk($sformatf("dup_ba%0d", k), a_dout, exp);
      consume_a();
      consume_b();
    end

    gl = 0;
    gl_en = 1;
    cycles(100);
    gl = 1;
    cycles(600);
    chk("glitch_no_valid", b_ovld, 0);
    gl_en = 0;
    send_a(8'h5C);
    wait_a_idle(n);
    chk("post_glitch_valid", b_ovld, 1);
    chk("post_glitch_data", b_dout, 8'h5C);
    consume_b();

    send_a(8'h96);
    cycles(2000);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_so", a_so, 1);
    chk("mid_rst_rdy", a_irdy, 1);
    chk("mid_rst_valid", b_ovld, 0);
    chk("mid_rst_dout", b_dout, 8'h00);
    cycles(3000);
    chk("mid_rst_discard", b_ovld, 0);
    chk("mid_rst_so_idle", a_so, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART with a valid/ready byte interface on each side.
- Used both as the CPU's on-chip memory-mapped UART and as the off-chip bench UART, cross-connected: serial_out of one drives serial_in of the other.
- Contains an independent transmitter and receiver; the only shared state is the clock and reset.

Parameters:
- CLOCK_FREQ, 125_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate.
- SYMBOL_EDGE_TIME (derived, not overridable) = CLOCK_FREQ / BAUD_RATE, integer division. This is clk cycles per bit; 434 at 50 MHz.
- SAMPLE_TIME (derived) = SYMBOL_EDGE_TIME / 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  byte to transmit.
- data_in_valid  in  1  transmit request.
- data_in_ready  out  1  transmitter idle, can accept a byte.
- data_out  out  8  last received byte.
- data_out_valid  out  1  data_out holds an unconsumed byte.
- data_out_ready  in  1  consumer accepts data_out.
- serial_in  in  1  RX line, asynchronous, idle high.
- serial_out  out  1  TX line, idle high.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: serial_out=1, data_in_ready=1, data_out_valid=0, data_out=8'h00; all counters are cleared and both FSMs go to IDLE.
- Reset mid-frame aborts immediately: serial_out returns high the next cycle and any partial RX byte is discarded.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Each bit lasts exactly SYMBOL_EDGE_TIME cycles.

Transmitter:
- data_in_ready = 1 only in TX IDLE.
- A byte is accepted on a rising edge where data_in_valid && data_in_ready. data_in is latched into a 10-bit shift register {1, data, 0}.
- Cycle after accept: data_in_ready=0 and serial_out drives the start bit.
- Each bit is held SYMBOL_EDGE_TIME cycles.
- After the stop bit completes (10*SYMBOL_EDGE_TIME cycles after the start bit began), TX returns to IDLE and data_in_ready=1.
- data_in_valid while busy is ignored, not queued.
- data_in may change after the accept edge without affecting the frame in flight.
- Back-to-back requests give frames with no idle gap beyond one cycle.

Receiver:
- serial_in passes through a 2-flop synchronizer; all RX decisions use the synchronized value.
- RX IDLE → START on a synchronized low.
- In START, the line is sampled at SAMPLE_TIME:
  - if high, false start: back to IDLE, no output;
  - else proceed to DATA.
- In DATA, 8 bits are sampled, each SYMBOL_EDGE_TIME after the previous sample, and shifted in LSB first.
- In STOP, one more sample is taken. The stop-bit value is not checked; framing errors are not reported.
- Cycle after the stop sample: data_out <= received byte, data_out_valid <= 1, RX → IDLE.
- data_out_valid stays 1 until a rising edge with data_out_ready=1; it clears the next cycle. data_out is stable while valid.
- A new frame may be received while data_out_valid=1. On completion it overwrites data_out and valid stays 1; the older byte is lost, with no error flag.
- Completion and data_out_ready in the same cycle: the new byte wins and data_out_valid remains 1.

Independence:
- TX and RX run concurrently with no interaction.
- Tying serial_out to serial_in (loopback) must receive exactly what was sent.

Test Plan:
- Two instances cross-connected at CLOCK_FREQ=50_000_000 and default BAUD_RATE. After reset, A sends 8'h7A: A data_in_ready drops the cycle after accept and returns high within 4340+2 cycles. B data_out_valid=1 with data_out=8'h7A within ~4345 cycles. Asserting data_out_ready for one cycle clears valid the next cycle.
- Serial waveform check, sending 8'hA5: serial_out reads 0,1,0,1,0,0,1,0,1,1, each bit exactly 434 cycles, then idle high.
- data_in_valid pulsed mid-frame with 8'h33 while sending 8'h7A: ignored; only 8'h7A is transmitted. Back-to-back 8'h01 then 8'hFF on ready: both received in order.
- Without consuming, receive 8'h11 then 8'h22: data_out=8'h22 and data_out_valid stays 1 throughout.
- Glitch: serial_in low for 100 cycles (< SAMPLE_TIME) then high: no data_out_valid, RX back in IDLE, and the next valid frame 8'h5C is received correctly.
- reset asserted mid-TX frame: serial_out=1 and data_in_ready=1 the cycle after reset; partial RX discarded, data_out_valid=0, data_out=8'h00.
